uart_tx_arbiter: RTL and testbench

//  Shares the single UART transmitter among NUM_REQ byte requesters using round-robin arbitration.

---
 rtl/uart_tx_arbiter_pkg.sv | 25 ++
 rtl/uart_tx_arbiter_rr.sv | 35 +++
 rtl/uart_tx_arbiter.sv | 174 +++++++++++++++++
 tb/tb_uart_tx_arbiter.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_tx_arbiter_pkg.sv
// Shared definitions for the UART transmit-side controller.
// The state encoding is fixed so the future rx-side controller can reuse it.
package uart_tx_arbiter_pkg;

    // Controller states, fixed encodings
    typedef enum logic [1:0] {
        StIdle     = 2'd0,
        StLaunch   = 2'd1,
        StWaitDone = 2'd2,
        StRecover  = 2'd3
    } ctrl_state_e;

    // Supported requester count range
    localparam int unsigned NumReqMin = 2;
    localparam int unsigned NumReqMax = 8;

    // Index to one-hot over the widest supported requester vector
    function automatic logic [NumReqMax-1:0] id_to_onehot(input logic [2:0] id);
        logic [NumReqMax-1:0] oh;
        oh     = '0;
        oh[id] = 1'b1;
        return oh;
    endfunction

endpackage

// File: rtl/uart_tx_arbiter_rr.sv
// Combinational round-robin pick: first requester after last_i, wrapping.
module uart_tx_arbiter_rr #(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned IdW     = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [IdW-1:0]     last_i,
    output logic [IdW-1:0]     grant_o,
    output logic               any_o
);

    // One extra bit holds last_i + offset before the wrap (max 2*NUM_REQ-1)
    logic [IdW:0] sum;
    logic [IdW-1:0] idx;

    // Scan offsets 1..NUM_REQ from the last owner; the first hit wins
    always_comb begin
        grant_o = '0;
        any_o   = 1'b0;
        sum     = '0;
        idx     = '0;
        for (int unsigned off = 1; off <= NUM_REQ; off++) begin
            sum = {1'b0, last_i} + (IdW + 1)'(off);
            if (sum >= (IdW + 1)'(NUM_REQ)) begin
                sum = sum - (IdW + 1)'(NUM_REQ);
            end
            idx = IdW'(sum);
            if (!any_o && req_i[idx]) begin
                any_o   = 1'b1;
                grant_o = idx;
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter among NUM_REQ byte producers.
// One byte is accepted per grant, launched to the transmitter, and its completion
// reported back. A per-transfer watchdog resets a hung transmitter.
// NUM_REQ must lie within NumReqMin..NumReqMax.
module uart_tx_arbiter
    import uart_tx_arbiter_pkg::*;
#(
    parameter int unsigned NUM_REQ   = 4,
    parameter int unsigned WIDTH8    = 8,
    parameter int unsigned TIMEOUT_W = 20
) (
    input  logic                        PCLK,
    input  logic                        PRESET,
    input  logic                        enable,
    input  logic [TIMEOUT_W-1:0]        timeout_cycles,
    input  logic [NUM_REQ-1:0]          req_valid,
    input  logic [NUM_REQ*WIDTH8-1:0]   req_data,
    output logic [NUM_REQ-1:0]          req_ready,
    output logic [NUM_REQ-1:0]          req_sent,
    output logic                        tx_en,
    output logic [WIDTH8-1:0]           tx_data,
    output logic                        tx_rst,
    input  logic                        tx_busy,
    input  logic                        tx_done,
    output logic [$clog2(NUM_REQ)-1:0]  grant_id,
    output logic                        ctrl_busy,
    output logic                        timeout_err,
    input  logic                        err_clr
);

    localparam int unsigned IdW = $clog2(NUM_REQ);

    ctrl_state_e          state_q, state_d;
    logic [IdW-1:0]       last_q, last_d;
    logic [IdW-1:0]       grant_q, grant_d;
    logic [WIDTH8-1:0]    hold_q, hold_d;
    logic [TIMEOUT_W-1:0] cnt_q, cnt_d;
    logic [NUM_REQ-1:0]   ready_q, ready_d;
    logic [NUM_REQ-1:0]   sent_q, sent_d;
    logic                 tx_en_q, tx_en_d;
    logic                 tx_rst_q, tx_rst_d;
    logic                 busy_q, busy_d;
    logic                 err_q, err_d;

    logic [IdW-1:0]       pick;
    logic                 any_req;
    logic [WIDTH8-1:0]    req_bytes [NUM_REQ];
    logic [TIMEOUT_W-1:0] cnt_inc;
    logic                 wd_expire;
    logic                 err_set;

    // Unpack the flat data bus into one byte per requester
    for (genvar g = 0; g < NUM_REQ; g++) begin : gen_bytes
        assign req_bytes[g] = req_data[g*WIDTH8 +: WIDTH8];
    end

    uart_tx_arbiter_rr #(
        .NUM_REQ (NUM_REQ),
        .IdW     (IdW)
    ) u_rr (
        .req_i   (req_valid),
        .last_i  (last_q),
        .grant_o (pick),
        .any_o   (any_req)
    );

    // Watchdog helpers: saturating increment and expiry on the last allowed cycle
    always_comb begin
        cnt_inc   = (&cnt_q) ? cnt_q : cnt_q + TIMEOUT_W'(1);
        wd_expire = (timeout_cycles != '0) && (cnt_q == timeout_cycles - TIMEOUT_W'(1));
    end

    // Next-state logic for the FSM, hold register, watchdog and pulses
    always_comb begin
        state_d  = state_q;
        last_d   = last_q;
        grant_d  = grant_q;
        hold_d   = hold_q;
        cnt_d    = cnt_q;
        ready_d  = '0;
        sent_d   = '0;
        tx_rst_d = 1'b0;
        err_set  = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (enable && any_req) begin
                    grant_d = pick;
                    hold_d  = req_bytes[pick];
                    ready_d = NUM_REQ'(id_to_onehot(3'(pick)));
                    cnt_d   = '0;
                    state_d = StLaunch;
                end
            end
            StLaunch: begin
                cnt_d = cnt_inc;
                // Busy beats a simultaneous expiry
                if (tx_busy) begin
                    state_d = StWaitDone;
                end else if (wd_expire) begin
                    state_d  = StRecover;
                    tx_rst_d = 1'b1;
                    err_set  = 1'b1;
                    last_d   = grant_q;
                end
            end
            StWaitDone: begin
                cnt_d = cnt_inc;
                // Done beats a simultaneous expiry
                if (tx_done) begin
                    sent_d  = NUM_REQ'(id_to_onehot(3'(grant_q)));
                    last_d  = grant_q;
                    state_d = StIdle;
                end else if (wd_expire) begin
                    state_d  = StRecover;
                    tx_rst_d = 1'b1;
                    err_set  = 1'b1;
                    last_d   = grant_q;
                end
            end
            StRecover: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        // tx_en rises one cycle after the grant and falls with the LAUNCH exit
        tx_en_d = (state_q == StLaunch) && (state_d == StLaunch);
        busy_d  = (state_d != StIdle);
        // Set wins over a same-cycle clear
        err_d   = err_set | (err_q & ~err_clr);
    end

    // State and registered outputs; reset forces every output low at once
    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            state_q  <= StIdle;
            last_q   <= IdW'(NUM_REQ - 1);
            grant_q  <= '0;
            hold_q   <= '0;
            cnt_q    <= '0;
            ready_q  <= '0;
            sent_q   <= '0;
            tx_en_q  <= 1'b0;
            tx_rst_q <= 1'b0;
            busy_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            last_q   <= last_d;
            grant_q  <= grant_d;
            hold_q   <= hold_d;
            cnt_q    <= cnt_d;
            ready_q  <= ready_d;
            sent_q   <= sent_d;
            tx_en_q  <= tx_en_d;
            tx_rst_q <= tx_rst_d;
            busy_q   <= busy_d;
            err_q    <= err_d;
        end
    end

    assign req_ready   = ready_q;
    assign req_sent    = sent_q;
    assign tx_en       = tx_en_q;
    assign tx_data     = hold_q;
    assign tx_rst      = tx_rst_q;
    assign grant_id    = grant_q;
    assign ctrl_busy   = busy_q;
    assign timeout_err = err_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: a table of full transfers plus hand-written
// watchdog, race, enable and reset sequences.
module tb_uart_tx_arbiter;

    logic        PCLK = 1'b0;
    logic        PRESET = 1'b1;
    logic        enable = 1'b0;
    logic [19:0] timeout_cycles = '0;
    logic [3:0]  req_valid = '0;
    logic [31:0] req_data = '0;
    logic        tx_busy = 1'b0;
    logic        tx_done = 1'b0;
    logic        err_clr = 1'b0;
    logic [3:0]  req_ready;
    logic [3:0]  req_sent;
    logic        tx_en;
    logic [7:0]  tx_data;
    logic        tx_rst;
    logic [1:0]  grant_id;
    logic        ctrl_busy;
    logic        timeout_err;

    int n_pass = 0;
    int n_total = 0;

    uart_tx_arbiter #(
        .NUM_REQ   (4),
        .WIDTH8    (8),
        .TIMEOUT_W (20)
    ) dut (
        .PCLK           (PCLK),
        .PRESET         (PRESET),
        .enable         (enable),
        .timeout_cycles (timeout_cycles),
        .req_valid      (req_valid),
        .req_data       (req_data),
        .req_ready      (req_ready),
        .req_sent       (req_sent),
        .tx_en          (tx_en),
        .tx_data        (tx_data),
        .tx_rst         (tx_rst),
        .tx_busy        (tx_busy),
        .tx_done        (tx_done),
        .grant_id       (grant_id),
        .ctrl_busy      (ctrl_busy),
        .timeout_err    (timeout_err),
        .err_clr        (err_clr)
    );

    always #5 PCLK = ~PCLK;

    typedef struct {
        logic [3:0]  valid;
        logic [31:0] data;
        int          grant;
        logic [7:0]  exp_byte;
    } vec_t;

    vec_t vecs [10];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge PCLK);
        #1;
    endtask

    // Wait (bounded) for a req_ready pulse and check who got it
    task automatic wait_ready(input int eg);
        int  cyc = 0;
        bit  seen = 0;
        while (!seen && cyc < 10) begin
            tick();
            cyc++;
            if (req_ready != 4'b0) seen = 1;
        end
        chk("ready_seen", 32'(seen), 32'd1);
        chk("ready_onehot", 32'(req_ready), 32'd1 << eg);
        chk("grant_id", 32'(grant_id), 32'(eg));
        chk("busy_on_grant", 32'(ctrl_busy), 32'd1);
        chk("tx_en_not_yet", 32'(tx_en), 32'd0);
    endtask

    // Wait (bounded) for tx_rst, returning cycles elapsed since the call
    task automatic wait_rst(output int cyc);
        cyc = 0;
        while (tx_rst !== 1'b1 && cyc < 40) begin
            tick();
            cyc++;
        end
    endtask

    // Full well-behaved transfer: grant, launch, busy, done
    task automatic xfer(input logic [3:0] v, input logic [31:0] d, input int eg,
                        input logic [7:0] eb);
        req_valid = v;
        req_data  = d;
        wait_ready(eg);
        tick();
        chk("tx_en_launch", 32'(tx_en), 32'd1);
        chk("tx_data", 32'(tx_data), 32'(eb));
        chk("ready_pulse_1cyc", 32'(req_ready), 32'd0);
        tx_busy = 1'b1;
        tick();
        chk("tx_en_drop_on_busy", 32'(tx_en), 32'd0);
        chk("no_sent_yet", 32'(req_sent), 32'd0);
        tick();
        tx_busy = 1'b0;
        tx_done = 1'b1;
        tick();
        tx_done = 1'b0;
        req_valid = '0;
        chk("sent_onehot", 32'(req_sent), 32'd1 << eg);
        chk("idle_after_done", 32'(ctrl_busy), 32'd0);
    endtask

    initial begin
        int  cyc;
        bit  ok;

        // Reset state
        #2;
        chk("rst_tx_en", 32'(tx_en), 32'd0);
        chk("rst_tx_rst", 32'(tx_rst), 32'd0);
        chk("rst_ready", 32'(req_ready), 32'd0);
        chk("rst_sent", 32'(req_sent), 32'd0);
        chk("rst_grant", 32'(grant_id), 32'd0);
        chk("rst_busy", 32'(ctrl_busy), 32'd0);
        chk("rst_err", 32'(timeout_err), 32'd0);
        chk("rst_tx_data", 32'(tx_data), 32'd0);
        @(posedge PCLK);
        @(posedge PCLK);
        #1;
        PRESET = 1'b0;
        enable = 1'b1;

        // Round-robin table, watchdog off; last owner after reset is 3
        vecs[0] = '{4'b1111, 32'h44332211, 0, 8'h11};
        vecs[1] = '{4'b1111, 32'h44332211, 1, 8'h22};
        vecs[2] = '{4'b1111, 32'h44332211, 2, 8'h33};
        vecs[3] = '{4'b1111, 32'h44332211, 3, 8'h44};
        vecs[4] = '{4'b1111, 32'h88776655, 0, 8'h55};
        vecs[5] = '{4'b0100, 32'h00A50000, 2, 8'hA5};
        vecs[6] = '{4'b1001, 32'h9C0000E1, 3, 8'h9C};
        vecs[7] = '{4'b1001, 32'h9C0000E1, 0, 8'hE1};
        vecs[8] = '{4'b0010, 32'h00007E00, 1, 8'h7E};
        vecs[9] = '{4'b0011, 32'h00003CB2, 0, 8'hB2};
        for (int i = 0; i < 10; i++) begin
            xfer(vecs[i].valid, vecs[i].data, vecs[i].grant, vecs[i].exp_byte);
        end

        // Watchdog: no tx_busy ever; 16 cycles in LAUNCH then RECOVER
        timeout_cycles = 20'd16;
        req_valid = 4'b1111;
        req_data  = 32'h0BADF00D;
        wait_ready(1);
        req_valid = '0;
        wait_rst(cyc);
        chk("wd_cycles", 32'(cyc), 32'd16);
        chk("wd_tx_en_low", 32'(tx_en), 32'd0);
        chk("wd_err_set", 32'(timeout_err), 32'd1);
        chk("wd_no_sent", 32'(req_sent), 32'd0);
        tick();
        chk("wd_rst_1cyc", 32'(tx_rst), 32'd0);
        chk("wd_back_idle", 32'(ctrl_busy), 32'd0);
        repeat (3) tick();
        chk("wd_err_sticky", 32'(timeout_err), 32'd1);
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        chk("err_clr", 32'(timeout_err), 32'd0);
        xfer(4'b1111, 32'h44332211, 2, 8'h33);

        // Race: tx_done on the exact expiry cycle; done wins
        req_valid = 4'b1111;
        wait_ready(3);
        req_valid = '0;
        tx_busy = 1'b1;
        ok = 1;
        for (int i = 0; i < 15; i++) begin
            tick();
            if (tx_rst !== 1'b0 || ctrl_busy !== 1'b1) ok = 0;
        end
        chk("race_hold_wait", 32'(ok), 32'd1);
        tx_busy = 1'b0;
        tx_done = 1'b1;
        tick();
        tx_done = 1'b0;
        chk("race_sent", 32'(req_sent), 32'b1000);
        chk("race_no_rst", 32'(tx_rst), 32'd0);
        chk("race_no_err", 32'(timeout_err), 32'd0);
        tick();
        chk("race_no_rst_late", 32'(tx_rst), 32'd0);

        // Enable dropped in WAIT_DONE, watchdog off: stall holds, byte completes
        timeout_cycles = '0;
        req_valid = 4'b0001;
        req_data  = 32'h000000C7;
        wait_ready(0);
        req_valid = '0;
        tx_busy = 1'b1;
        tick();
        enable = 1'b0;
        req_valid = 4'b1111;
        ok = 1;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (ctrl_busy !== 1'b1 || tx_rst !== 1'b0 || req_sent !== 4'b0) ok = 0;
        end
        chk("stall_holds", 32'(ok), 32'd1);
        tx_busy = 1'b0;
        tx_done = 1'b1;
        tick();
        tx_done = 1'b0;
        chk("en_off_sent", 32'(req_sent), 32'b0001);
        ok = 1;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (req_ready !== 4'b0 || ctrl_busy !== 1'b0) ok = 0;
            if (i == 3) tx_done = 1'b1;
            if (i == 4) tx_done = 1'b0;
            if (req_sent !== 4'b0) ok = 0;
        end
        chk("en_off_no_grant", 32'(ok), 32'd1);
        enable = 1'b1;
        xfer(4'b1111, 32'h44332211, 1, 8'h22);

        // Reset mid-LAUNCH after a short timeout has set the error flag
        timeout_cycles = 20'd4;
        req_valid = 4'b1111;
        wait_ready(2);
        req_valid = '0;
        wait_rst(cyc);
        chk("wd4_cycles", 32'(cyc), 32'd4);
        req_valid = 4'b0100;
        req_data  = 32'h005A0000;
        wait_ready(2);
        req_valid = '0;
        chk("pre_rst_err", 32'(timeout_err), 32'd1);
        tick();
        chk("pre_rst_tx_en", 32'(tx_en), 32'd1);
        #2;
        PRESET = 1'b1;
        #1;
        chk("arst_tx_en", 32'(tx_en), 32'd0);
        chk("arst_ready", 32'(req_ready), 32'd0);
        chk("arst_err", 32'(timeout_err), 32'd0);
        chk("arst_busy", 32'(ctrl_busy), 32'd0);
        chk("arst_tx_rst", 32'(tx_rst), 32'd0);
        @(posedge PCLK);
        #1;
        PRESET = 1'b0;
        timeout_cycles = '0;
        xfer(4'b1111, 32'h44332211, 0, 8'h11);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: bench did not reach its summary");
        $fatal(1);
    end

endmodule
